// File: rtl/led_ctrl_pkg.sv
// Shared types for the front-panel LED activity controller: display modes,
// scanner flavours and the LED-count derivation used by the top level.
// No ports; imported by led_scanner and led_activity_ctrl.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FAULT,
    MODE_HITS,
    MODE_IDLE
  } led_mode_e;

  typedef enum logic {
    SCAN_BOUNCE,
    SCAN_SWEEP
  } scan_kind_e;

  // One LED per distrip plus one LED per side.
  function automatic int led_count(input int nhs, input int nside);
    return nhs / nside + nside;
  endfunction

endpackage

// File: rtl/led_scanner.sv
// One-hot LED scanner; bounce (0..N-1..0, no repeated ends) or sweep (0..N-1, wrap).
// Latency: position advances on the edge where i_step is high; o_onehot follows r_pos.
// Backpressure: none, free-running whenever i_step pulses.
// Ports: i_clock, i_reset (async, active-high), i_step (advance strobe),
//        o_onehot [NLED-1:0] (current position, one bit set).
module led_scanner
  import led_ctrl_pkg::*;
#(
  parameter scan_kind_e KIND = SCAN_SWEEP,
  parameter int         NLED = 12
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_step,
  output logic [NLED-1:0] o_onehot
);

  localparam int            PW   = (NLED > 1) ? $clog2(NLED) : 1;
  localparam logic [PW-1:0] LAST = PW'(NLED - 1);

  logic [PW-1:0] r_pos;
  logic          r_dir_up;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pos    <= '0;
      r_dir_up <= 1'b1;
    end else if (i_step) begin
      if (KIND == SCAN_SWEEP) begin
        r_pos <= (r_pos == LAST) ? '0 : r_pos + 1'b1;
      end else if (r_dir_up) begin
        // Turn around at the top without dwelling on the end LED.
        if (r_pos == LAST) begin
          r_pos    <= r_pos - 1'b1;
          r_dir_up <= 1'b0;
        end else begin
          r_pos <= r_pos + 1'b1;
        end
      end else begin
        if (r_pos == '0) begin
          r_pos    <= r_pos + 1'b1;
          r_dir_up <= 1'b1;
        end else begin
          r_pos <= r_pos - 1'b1;
        end
      end
    end
  end

  assign o_onehot = NLED'(1) << r_pos;

endmodule

// File: rtl/led_activity_ctrl.sv
// Front-panel LED controller: halfstrip hits -> stretched distrip/side LEDs, scanners for fault/idle.
// Latency: hit -> stage1 (+1) -> stretcher load (+2) -> leds low (+3); mode change shows after 1 cycle.
// Backpressure: none; inputs sampled every cycle, outputs registered.
// Ports: clock; reset (async, active-high); dcms_locked; push_button (active-low);
//        pulser_ready (low = pulser busy); halfstrips [NHS-1:0];
//        leds [NLED-1:0] active-low, distrips in the low NHS/NSIDE bits, sides above;
//        busy (busy counter non-zero).
// Build option: define LED_RETRIGGER_EN to make the flash stretchers retriggerable.
module led_activity_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NHS        = 32,
  parameter int NSIDE      = 4,
  parameter int NLED       = led_count(NHS, NSIDE),
  parameter int STRETCH_W  = 22,
  parameter int BUSY_W     = 23,
  parameter int SCAN_DIV_W = 21
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dcms_locked,
  input  logic            push_button,
  input  logic            pulser_ready,
  input  logic [NHS-1:0]  halfstrips,
  output logic [NLED-1:0] leds,
  output logic            busy
);

  localparam int NDIS = NHS / NSIDE;

  // Stage 1: hit reduction onto distrip and side channels.
  logic [NDIS-1:0]  w_distrip;
  logic [NSIDE-1:0] w_side;
  logic [NDIS-1:0]  r_distrip;
  logic [NSIDE-1:0] r_side;

  always_comb begin
    w_distrip = '0;
    w_side    = '0;
    for (int d = 0; d < NDIS; d++) begin
      w_distrip[d] = |halfstrips[d*NSIDE +: NSIDE];
    end
    for (int s = 0; s < NSIDE; s++) begin
      for (int k = 0; k < NDIS; k++) begin
        w_side[s] = w_side[s] | halfstrips[s + k*NSIDE];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_distrip <= '0;
      r_side    <= '0;
    end else begin
      r_distrip <= w_distrip;
      r_side    <= w_side;
    end
  end

  // Stage 2: per-channel flash stretchers, channel order matches the leds bus.
  logic [NLED-1:0]      w_act;
  logic [NLED-1:0]      w_lit;
  logic [STRETCH_W-1:0] r_str [NLED];

  assign w_act = {r_side, r_distrip};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NLED; c++) r_str[c] <= '0;
    end else begin
      for (int c = 0; c < NLED; c++) begin
`ifdef LED_RETRIGGER_EN
        if (w_act[c]) r_str[c] <= '1;
`else
        // Only an expired stretcher accepts a new trigger.
        if (w_act[c] && (r_str[c] == '0)) r_str[c] <= '1;
`endif
        else if (r_str[c] != '0) r_str[c] <= r_str[c] - 1'b1;
      end
    end
  end

  always_comb begin
    w_lit = '0;
    for (int c = 0; c < NLED; c++) w_lit[c] = (r_str[c] != '0);
  end

  // Busy hold-off after the pulser reports busy.
  logic [BUSY_W-1:0] r_busy_cnt;
  logic              w_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (!pulser_ready) begin
      r_busy_cnt <= '1;
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

  assign w_busy = (r_busy_cnt != '0);
  assign busy   = w_busy;

  // Shared scanner prescaler: one step per full wrap.
  logic [SCAN_DIV_W-1:0] r_presc;
  logic                  w_step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_presc <= '0;
    else       r_presc <= r_presc + 1'b1;
  end

  assign w_step = &r_presc;

  logic [NLED-1:0] w_bounce;
  logic [NLED-1:0] w_sweep;

  led_scanner #(.KIND(SCAN_BOUNCE), .NLED(NLED)) u_bounce (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_step   (w_step),
    .o_onehot (w_bounce)
  );

  led_scanner #(.KIND(SCAN_SWEEP), .NLED(NLED)) u_sweep (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_step   (w_step),
    .o_onehot (w_sweep)
  );

  // Mode select and output register.
  led_mode_e       w_mode;
  logic [NLED-1:0] w_pattern;
  logic [NLED-1:0] r_leds;

  always_comb begin
    if (!push_button || !dcms_locked) w_mode = MODE_FAULT;
    else if (w_busy)                  w_mode = MODE_HITS;
    else                              w_mode = MODE_IDLE;
  end

  always_comb begin
    w_pattern = w_sweep;
    case (w_mode)
      MODE_FAULT: w_pattern = w_bounce;
      MODE_HITS:  w_pattern = w_lit;
      default:    w_pattern = w_sweep;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_leds <= '1;
    else       r_leds <= ~w_pattern;
  end

  assign leds = r_leds;

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Self-checking bench for led_activity_ctrl (NHS=8, NSIDE=4, NLED=6, short counters).
// A behavioural model pushes expected {leds,busy} per clock edge; scenario tasks pop at negedge.
// Build option: LED_RETRIGGER_EN changes the held-hit expectation.
module tb_led_activity_ctrl;

  localparam int NHS   = 8;
  localparam int NSIDE = 4;
  localparam int NDIS  = 2;
  localparam int NLED  = 6;
  localparam int SMAX  = 7;   // 2^STRETCH_W - 1
  localparam int BMAX  = 15;  // 2^BUSY_W - 1

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            dcms_locked = 1'b1;
  logic            push_button = 1'b1;
  logic            pulser_ready = 1'b1;
  logic [NHS-1:0]  halfstrips = '0;
  logic [NLED-1:0] leds;
  logic            busy;

  int n_tot = 0;
  int n_bad = 0;

  led_activity_ctrl #(
    .NHS(NHS), .NSIDE(NSIDE), .STRETCH_W(3), .BUSY_W(4), .SCAN_DIV_W(1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dcms_locked  (dcms_locked),
    .push_button  (push_button),
    .pulser_ready (pulser_ready),
    .halfstrips   (halfstrips),
    .leds         (leds),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Reference model: scanner positions derived from a step count, stretchers as counters.
  logic [6:0]      sb[$];
  int              m_str[NLED];
  int              m_busy  = 0;
  int              m_presc = 0;
  int              m_steps = 0;
  logic [NLED-1:0] m_act   = '0;

  always @(posedge clock or posedge reset) begin : mdl
    logic [NLED-1:0] pat;
    int sw, bt;
    if (reset) begin
      for (int c = 0; c < NLED; c++) m_str[c] = 0;
      m_busy = 0; m_presc = 0; m_steps = 0; m_act = '0;
      sb.delete();
    end else begin
      sw = m_steps % NLED;
      bt = m_steps % (2*NLED-2);
      if (bt >= NLED) bt = 2*NLED-2 - bt;
      pat = '0;
      if (!push_button || !dcms_locked) pat[bt] = 1'b1;
      else if (m_busy != 0) begin
        for (int c = 0; c < NLED; c++) pat[c] = (m_str[c] != 0);
      end else pat[sw] = 1'b1;
      for (int c = 0; c < NLED; c++) begin
`ifdef LED_RETRIGGER_EN
        if (m_act[c]) m_str[c] = SMAX;
`else
        if (m_act[c] && m_str[c] == 0) m_str[c] = SMAX;
`endif
        else if (m_str[c] > 0) m_str[c] = m_str[c] - 1;
      end
      m_act = '0;
      for (int i = 0; i < NHS; i++) begin
        if (halfstrips[i]) begin
          m_act[i / NSIDE] = 1'b1;
          m_act[NDIS + i % NSIDE] = 1'b1;
        end
      end
      if (!pulser_ready) m_busy = BMAX;
      else if (m_busy > 0) m_busy = m_busy - 1;
      if (m_presc == 1) m_steps = m_steps + 1;
      m_presc = (m_presc + 1) % 2;
      sb.push_back({~pat, (m_busy != 0)});
    end
  end

  task test_reset;
    logic [6:0] e;
    #1 reset = 1'b1;
    #2;
    n_tot++;
    if (leds !== 6'b111111) begin n_bad++; $display("FAIL reset_leds: got %b want 111111", leds); end
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL reset_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL reset_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (j < 2) begin
        n_tot++;
        if (leds !== 6'b111110) begin n_bad++; $display("FAIL reset_sweep0 cyc %0d: got %b want 111110", j, leds); end
      end
    end
  endtask

  task test_hit_flash;
    logic [6:0] e;
    logic [NLED-1:0] obs[12];
    int lit;
    pulser_ready = 1'b0;
    for (int j = -1; j < 12; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL flash_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL flash_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (j == -1) begin pulser_ready = 1'b1; halfstrips = 8'h01; end
      else begin
        obs[j] = leds;
        if (j == 0) halfstrips = '0;
      end
    end
    lit = 0;
    for (int j = 0; j < 12; j++) if (obs[j] == 6'b111010) lit++;
    n_tot++;
    if (obs[1] !== 6'b111111) begin n_bad++; $display("FAIL flash_early: got %b want 111111", obs[1]); end
    n_tot++;
    if (obs[2] !== 6'b111010) begin n_bad++; $display("FAIL flash_first: got %b want 111010", obs[2]); end
    n_tot++;
    if (obs[9] !== 6'b111111) begin n_bad++; $display("FAIL flash_end: got %b want 111111", obs[9]); end
    n_tot++;
    if (lit != SMAX) begin n_bad++; $display("FAIL flash_len: got %0d want %0d", lit, SMAX); end
  endtask

  task test_held_hit;
    logic [6:0] e;
    int lit, want;
    pulser_ready = 1'b0;
    halfstrips = 8'h80;
    lit = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL held_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL held_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (j >= 4 && leds == 6'b011101) lit++;
    end
`ifdef LED_RETRIGGER_EN
    want = 16;
`else
    want = 14;
`endif
    n_tot++;
    if (lit != want) begin n_bad++; $display("FAIL held_lit: got %0d lit of 16 want %0d", lit, want); end
  endtask

  task test_fault_bounce;
    logic [6:0] e;
    int pos, prev, nz, changes;
    dcms_locked = 1'b0;
    changes = 0;
    prev = -1;
    for (int j = 0; j < 21; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL bounce_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL bounce_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      pos = -1; nz = 0;
      for (int b = 0; b < NLED; b++) if (!leds[b]) begin pos = b; nz++; end
      n_tot++;
      if (nz != 1) begin n_bad++; $display("FAIL bounce_onehot: got leds=%b want one LED lit", leds); end
      if (j > 0 && pos != prev) changes++;
      prev = pos;
    end
    n_tot++;
    if (changes != 10) begin n_bad++; $display("FAIL bounce_steps: got %0d moves want 10", changes); end
    dcms_locked = 1'b1;
  endtask

  task test_busy_falloff;
    logic [6:0] e;
    int fall, pos, prev, changes, bad_dir;
    pulser_ready = 1'b1;
    halfstrips = '0;
    fall = -1; prev = -1; changes = 0; bad_dir = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL falloff_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL falloff_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (busy == 1'b0 && fall < 0) fall = k;
      pos = -1;
      for (int b = 0; b < NLED; b++) if (!leds[b]) pos = b;
      if (k >= 17 && pos != prev) begin
        changes++;
        if (pos != (prev + 1) % NLED) bad_dir++;
      end
      prev = pos;
    end
    n_tot++;
    if (fall != BMAX) begin n_bad++; $display("FAIL busy_fall: got %0d cycles want %0d", fall, BMAX); end
    n_tot++;
    if (changes != 7) begin n_bad++; $display("FAIL sweep_steps: got %0d moves want 7", changes); end
    n_tot++;
    if (bad_dir != 0) begin n_bad++; $display("FAIL sweep_dir: got %0d non-forward moves want 0", bad_dir); end
  endtask

  task test_button_fault;
    logic [6:0] e;
    int nz;
    push_button = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL button_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL button_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      nz = 0;
      for (int b = 0; b < NLED; b++) if (!leds[b]) nz++;
      n_tot++;
      if (nz != 1) begin n_bad++; $display("FAIL button_onehot: got leds=%b want one LED lit", leds); end
      if (j == 4) push_button = 1'b1;
    end
  endtask

  task test_reset_midflash;
    logic [6:0] e;
    pulser_ready = 1'b0;
    halfstrips = 8'h01;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL midflash_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL midflash_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (j == 0) halfstrips = '0;
    end
    n_tot++;
    if (leds !== 6'b111010) begin n_bad++; $display("FAIL midflash_lit: got %b want 111010", leds); end
    #2 reset = 1'b1;
    #1;
    n_tot++;
    if (leds !== 6'b111111) begin n_bad++; $display("FAIL midreset_leds: got %b want 111111", leds); end
    n_tot++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    pulser_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      n_tot++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL postreset_sb: no expected entry, leds=%b", leds); end
      else begin
        e = sb.pop_front();
        if ({leds, busy} !== e) begin
          n_bad++; $display("FAIL postreset_sb: got leds=%b busy=%b want leds=%b busy=%b", leds, busy, e[6:1], e[0]);
        end
      end
      if (j < 2) begin
        n_tot++;
        if (leds !== 6'b111110) begin n_bad++; $display("FAIL postreset_sweep0 cyc %0d: got %b want 111110", j, leds); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_flash();
    test_held_hit();
    test_fault_bounce();
    test_busy_falloff();
    test_button_fault();
    test_reset_midflash();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
